// File: rtl/imem_loader_pkg.sv
// Shared definitions for the boot-time instruction-memory loader.
package imem_loader_pkg;

  // Default instruction memory depth in words, shared with the writable imem.
  localparam int unsigned DefaultDepth = 64;

  typedef logic [2:0] state_t;

  localparam state_t StCntLo = 3'd0;
  localparam state_t StCntHi = 3'd1;
  localparam state_t StData  = 3'd2;
  localparam state_t StCheck = 3'd3;
  localparam state_t StDone  = 3'd4;
  localparam state_t StErr   = 3'd5;

endpackage

// File: rtl/imem_loader.sv
// Loads a length-prefixed, checksummed byte stream into instruction memory as
// little-endian 32-bit words, holding the core in reset until the image verifies.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned DEPTH = DefaultDepth,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [7:0]    rx_data,
  input  logic          rx_valid,
  output logic          rx_ready,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  output logic          cpu_reset,
  output logic          done,
  output logic          error
);

  state_t        state_q, state_d;
  logic [7:0]    cnt_lo_q, cnt_lo_d;
  logic [AW:0]   n_q, n_d;
  logic [AW:0]   word_idx_q, word_idx_d;
  logic [1:0]    byte_idx_q, byte_idx_d;
  logic [23:0]   word_q, word_d;
  logic [7:0]    sum_q, sum_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]   mem_wdata_q, mem_wdata_d;

  logic          accept;
  logic [15:0]   count_full;
  logic [7:0]    sum_next;
  logic [AW:0]   word_idx_inc;

  assign rx_ready     = (state_q == StCntLo) || (state_q == StCntHi) ||
                        (state_q == StData)  || (state_q == StCheck);
  assign accept       = rx_valid && rx_ready;
  assign count_full   = {rx_data, cnt_lo_q};
  assign sum_next     = sum_q + rx_data;
  assign word_idx_inc = word_idx_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    cnt_lo_d    = cnt_lo_q;
    n_d         = n_q;
    word_idx_d  = word_idx_q;
    byte_idx_d  = byte_idx_q;
    word_d      = word_q;
    sum_d       = accept ? sum_next : sum_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;

    if (accept) begin
      case (state_q)
        StCntLo: begin
          cnt_lo_d = rx_data;
          state_d  = StCntHi;
        end
        StCntHi: begin
          n_d = count_full[AW:0];
          if (32'(count_full) > DEPTH) begin
            state_d = StErr;
          end else if (count_full == 16'd0) begin
            state_d = StCheck;
          end else begin
            state_d = StData;
          end
        end
        StData: begin
          byte_idx_d = byte_idx_q + 2'd1;
          unique case (byte_idx_q)
            2'd0: word_d[7:0]   = rx_data;
            2'd1: word_d[15:8]  = rx_data;
            2'd2: word_d[23:16] = rx_data;
            2'd3: begin
              mem_we_d    = 1'b1;
              mem_addr_d  = word_idx_q[AW-1:0];
              mem_wdata_d = {rx_data, word_q};
              word_idx_d  = word_idx_inc;
              // Last word's write and CHECK entry share this edge.
              if (word_idx_inc == n_q) state_d = StCheck;
            end
            default: ;
          endcase
        end
        StCheck: state_d = (sum_next == 8'd0) ? StDone : StErr;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StCntLo;
      cnt_lo_q    <= '0;
      n_q         <= '0;
      word_idx_q  <= '0;
      byte_idx_q  <= '0;
      word_q      <= '0;
      sum_q       <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_lo_q    <= cnt_lo_d;
      n_q         <= n_d;
      word_idx_q  <= word_idx_d;
      byte_idx_q  <= byte_idx_d;
      word_q      <= word_d;
      sum_q       <= sum_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign cpu_reset = (state_q != StDone);
  assign done      = (state_q == StDone);
  assign error     = (state_q == StErr);

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: table-driven happy path plus hand-written
// sequences for checksum, oversize, zero/full length and mid-load reset.
module tb_imem_loader;

  logic        clk;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        mem_we;
  logic [5:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_reset;
  logic        done;
  logic        error;

  imem_loader dut (
    .clk       (clk),
    .reset     (reset),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_reset (cpu_reset),
    .done      (done),
    .error     (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  data;
    logic        valid;
    logic [42:0] exp;
  } vec_t;

  int nvec  = 0;
  int nfail = 0;

  // Write log, filled only by the monitor.
  int          wr_count = 0;
  logic [5:0]  log_addr [0:511];
  logic [31:0] log_data [0:511];

  always @(negedge clk) begin
    if (mem_we) begin
      log_addr[wr_count] <= mem_addr;
      log_data[wr_count] <= mem_wdata;
      wr_count <= wr_count + 1;
    end
  end

  function automatic logic [42:0] pk(input logic r, input logic we, input logic [5:0] a,
                                     input logic [31:0] d, input logic c, input logic dn,
                                     input logic e);
    return {r, we, a, d, c, dn, e};
  endfunction

  function automatic logic [42:0] obs();
    return pk(rx_ready, mem_we, mem_addr, mem_wdata, cpu_reset, done, error);
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic do_reset();
    rx_valid = 1'b0;
    reset    = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  logic [7:0] happy [0:10];
  vec_t       tbl   [0:13];

  localparam logic [42:0] RstVec = {1'b1, 1'b0, 6'd0, 32'h0, 1'b1, 1'b0, 1'b0};

  initial begin
    int          base;
    logic [7:0]  sum;
    logic [31:0] wd;

    happy = '{8'h02, 8'h00, 8'h05, 8'h00, 8'hA0, 8'hE3, 8'h01, 8'h10, 8'h80, 8'hE2, 8'h03};

    tbl[0]  = '{8'h02, 1'b1, pk(1, 0, 0, 32'h0, 1, 0, 0)};
    tbl[1]  = '{8'h00, 1'b1, pk(1, 0, 0, 32'h0, 1, 0, 0)};
    tbl[2]  = '{8'h05, 1'b1, pk(1, 0, 0, 32'h0, 1, 0, 0)};
    tbl[3]  = '{8'h77, 1'b0, pk(1, 0, 0, 32'h0, 1, 0, 0)};
    tbl[4]  = '{8'h00, 1'b1, pk(1, 0, 0, 32'h0, 1, 0, 0)};
    tbl[5]  = '{8'hA0, 1'b1, pk(1, 0, 0, 32'h0, 1, 0, 0)};
    tbl[6]  = '{8'hE3, 1'b1, pk(1, 1, 0, 32'hE3A00005, 1, 0, 0)};
    tbl[7]  = '{8'h01, 1'b0, pk(1, 0, 0, 32'hE3A00005, 1, 0, 0)};
    tbl[8]  = '{8'h01, 1'b1, pk(1, 0, 0, 32'hE3A00005, 1, 0, 0)};
    tbl[9]  = '{8'h10, 1'b1, pk(1, 0, 0, 32'hE3A00005, 1, 0, 0)};
    tbl[10] = '{8'h80, 1'b1, pk(1, 0, 0, 32'hE3A00005, 1, 0, 0)};
    tbl[11] = '{8'hE2, 1'b1, pk(1, 1, 1, 32'hE2801001, 1, 0, 0)};
    tbl[12] = '{8'h03, 1'b1, pk(0, 0, 1, 32'hE2801001, 0, 1, 0)};
    tbl[13] = '{8'hFF, 1'b1, pk(0, 0, 1, 32'hE2801001, 0, 1, 0)};

    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    #3;
    chk("reset_state", obs(), RstVec);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Happy path with gaps, cycle by cycle.
    base = wr_count;
    for (int i = 0; i < 14; i++) begin
      rx_data  = tbl[i].data;
      rx_valid = tbl[i].valid;
      @(posedge clk);
      #1;
      chk($sformatf("tbl%0d", i), obs(), tbl[i].exp);
    end
    rx_valid = 1'b0;
    idle(1);
    chk("happy_wr_count", 64'(wr_count - base), 64'd2);

    // Random gaps: same end result.
    do_reset();
    base = wr_count;
    for (int i = 0; i < 11; i++) begin
      idle($urandom_range(0, 3));
      send(happy[i]);
    end
    idle(2);
    chk("gap_wr_count", 64'(wr_count - base), 64'd2);
    chk("gap_w0", {log_addr[base], log_data[base]}, {6'd0, 32'hE3A00005});
    chk("gap_w1", {log_addr[base+1], log_data[base+1]}, {6'd1, 32'hE2801001});
    chk("gap_final", obs(), pk(0, 0, 1, 32'hE2801001, 0, 1, 0));

    // Bad checksum.
    do_reset();
    base = wr_count;
    for (int i = 0; i < 10; i++) send(happy[i]);
    send(8'h04);
    idle(1);
    chk("badck_wr_count", 64'(wr_count - base), 64'd2);
    chk("badck_w1", {log_addr[base+1], log_data[base+1]}, {6'd1, 32'hE2801001});
    chk("badck_final", obs(), pk(0, 0, 1, 32'hE2801001, 1, 0, 1));

    // Oversize count.
    do_reset();
    base = wr_count;
    send(8'h41);
    chk("over_after_lo", obs(), RstVec);
    send(8'h00);
    chk("over_err", obs(), pk(0, 0, 0, 32'h0, 1, 0, 1));
    for (int i = 0; i < 8; i++) send(8'h00);
    chk("over_ignored", obs(), pk(0, 0, 0, 32'h0, 1, 0, 1));
    chk("over_no_write", 64'(wr_count - base), 64'd0);

    // Zero length.
    do_reset();
    base = wr_count;
    send(8'h00);
    send(8'h00);
    chk("zero_check_state", obs(), RstVec);
    send(8'h00);
    chk("zero_done", obs(), pk(0, 0, 0, 32'h0, 0, 1, 0));
    chk("zero_no_write", 64'(wr_count - base), 64'd0);

    // Full size, N = 64.
    do_reset();
    base = wr_count;
    sum  = 8'h40;
    send(8'h40);
    send(8'h00);
    for (int w = 0; w < 64; w++) begin
      wd = {8'(w + 17), 8'(~w), 8'(w ^ 8'h5A), 8'(w)};
      for (int k = 0; k < 4; k++) begin
        sum = sum + wd[8*k +: 8];
        send(wd[8*k +: 8]);
      end
    end
    chk("full_pre_ck", obs(), pk(1, 1, 63, {8'd80, 8'hC0, 8'(63 ^ 8'h5A), 8'd63}, 1, 0, 0));
    send(8'(-sum));
    chk("full_done", obs(), pk(0, 0, 63, {8'd80, 8'hC0, 8'(63 ^ 8'h5A), 8'd63}, 0, 1, 0));
    idle(1);
    chk("full_wr_count", 64'(wr_count - base), 64'd64);
    for (int w = 0; w < 64; w += 9) begin
      wd = {8'(w + 17), 8'(~w), 8'(w ^ 8'h5A), 8'(w)};
      chk($sformatf("full_w%0d", w), {log_addr[base+w], log_data[base+w]}, {6'(w), wd});
    end
    chk("full_w63", {log_addr[base+63], log_data[base+63]},
        {6'd63, 8'd80, 8'hC0, 8'(63 ^ 8'h5A), 8'd63});

    // Mid-load asynchronous reset after 6 bytes, then a fresh stream.
    do_reset();
    for (int i = 0; i < 6; i++) send(happy[i]);
    chk("mid_pre_reset", obs(), pk(1, 1, 0, 32'hE3A00005, 1, 0, 0));
    reset = 1'b1;
    #1;
    chk("mid_async_clear", obs(), RstVec);
    @(posedge clk);
    #1;
    reset = 1'b0;
    base = wr_count;
    for (int i = 0; i < 11; i++) send(happy[i]);
    idle(1);
    chk("mid_wr_count", 64'(wr_count - base), 64'd2);
    chk("mid_w0", {log_addr[base], log_data[base]}, {6'd0, 32'hE3A00005});
    chk("mid_w1", {log_addr[base+1], log_data[base+1]}, {6'd1, 32'hE2801001});
    chk("mid_final", obs(), pk(0, 0, 1, 32'hE2801001, 0, 1, 0));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader that writes the instruction memory from a serial byte stream, typically a UART receiver. It accepts a length-prefixed, checksummed image, assembles little-endian 32-bit words and drives a writable instruction-memory port one word per write. It holds the ARM single-cycle core in reset until the image is fully written and verified, then releases it.

## Interface
- DEPTH, 64: instruction memory size in words; maximum accepted word count.
- AW, $clog2(DEPTH): word-address width.

- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- rx_data  in  8  incoming byte
- rx_valid  in  1  rx_data holds a byte
- rx_ready  out  1  loader can accept a byte; byte consumed on an edge with rx_valid && rx_ready
- mem_we  out  1  one-cycle write strobe to instruction memory
- mem_addr  out  AW  word address (byte address = mem_addr << 2)
- mem_wdata  out  32  word to write
- cpu_reset  out  1  held high until a verified load completes
- done  out  1  load completed and checksum correct
- error  out  1  load aborted (oversize count or bad checksum)

## Operation
- Stream format: CNT_LO, CNT_HI (16-bit word count N, little-endian), then 4·N data bytes, then one checksum byte. Valid image: 8-bit sum of every byte, including the count bytes and the checksum byte, equals 0x00.
- States: CNT_LO → CNT_HI → DATA → CHECK → DONE | ERR.
  - CNT_LO: accept a byte, store it as count[7:0], go to CNT_HI.
  - CNT_HI: accept a byte and form N. If N > DEPTH, go to ERR. If N = 0, go to CHECK. Otherwise go to DATA.
  - DATA: byte k of each word goes to bits [8k+7:8k], so the first byte is the LSB. After the 4th byte, issue a write at the current word index and increment the index. After word N−1, go to CHECK.
  - CHECK: accept one byte. Go to DONE if the running sum including this byte is 0, else go to ERR.
  - DONE and ERR: terminal states. Only reset leaves them.
- A running 8-bit sum accumulates every accepted byte and wraps mod 256.
- Word index is AW+1 bits internally, so N = DEPTH does not wrap. mem_addr is its low AW bits.
- rx_ready is decoded from state: 1 in CNT_LO, CNT_HI, DATA and CHECK; 0 in DONE and ERR. Bytes arriving while rx_ready = 0 are ignored.
- cpu_reset = 1 in every state except DONE. error = 1 only in ERR. done = 1 only in DONE.
- Words already written before an ERR stay in memory. The core still stays in reset.

## Timing
- Reset values: state CNT_LO, rx_ready 1, mem_we 0, mem_addr 0, mem_wdata 0, cpu_reset 1, done 0, error 0, sum 0, byte and word counters 0.
- mem_we, mem_addr and mem_wdata are registered. The write occurs in the cycle after the edge that consumed the 4th byte of a word. mem_we is high for exactly 1 cycle.
- mem_addr and mem_wdata hold their last values when mem_we = 0.
- One byte can be accepted per cycle. rx_valid may stay high continuously or have gaps; the loader imposes no minimum spacing.
- The last word's write and the entry to CHECK happen on the same edge. A checksum byte arriving the very next cycle is accepted.
- done rises and cpu_reset falls on the edge after the checksum byte is accepted. error rises on the edge after the failing CNT_HI or checksum byte.
- Reset asserted mid-load clears all registers immediately. The next stream restarts at CNT_LO and word 0.

## Structure
- Package imem_loader_pkg holds:
  - the state enum (CNT_LO, CNT_HI, DATA, CHECK, DONE, ERR);
  - the default DEPTH constant of 64, shared with the writable instruction memory.
- Single module, no sub-module. The word packer and checksum are small enough to stay inline.

## Test plan
- Happy path: send 02 00 05 00 A0 E3 01 10 80 E2 03.
  - Writes addr 0 = 0xE3A00005, then addr 1 = 0xE2801001, one mem_we pulse each.
  - Then done = 1, cpu_reset = 0, rx_ready = 0.
- Bad checksum: same stream with final byte 04.
  - Both writes still occur.
  - error = 1, done = 0, cpu_reset stays 1, rx_ready = 0.
- Oversize: send 41 00 (N = 65 with DEPTH = 64).
  - error = 1 on the next edge, no mem_we ever.
  - Further bytes ignored.
- Zero-length and full-size:
  - Send 00 00 00: done = 1, no writes.
  - Send N = 64 with valid checksum: last write at addr 63, then done.
- Backpressure-free gaps and mid-load reset:
  - Randomly deassert rx_valid during the happy-path stream; results must be identical.
  - Assert reset after 6 bytes: all outputs return to reset values. A fresh full stream then loads correctly starting at addr 0.
